// File: rtl/asp_irq_ctrl.sv
// rtl/asp_irq_ctrl.sv - ASP interrupt aggregation: edge capture, CSRs, round-robin vectored requests
module asp_irq_ctrl #(
  parameter int NUM_IRQ_LINES  = 4,
  parameter int NUM_IRQ_USED   = 3,
  parameter int CSR_ADDR_WIDTH = 3,
  parameter int CSR_DATA_WIDTH = 64,
  localparam int VEC_WIDTH = (NUM_IRQ_LINES > 1) ? $clog2(NUM_IRQ_LINES) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_IRQ_LINES-1:0]      irq_in,
  input  logic [CSR_ADDR_WIDTH-1:0]     avmm_address,
  input  logic                          avmm_read,
  input  logic                          avmm_write,
  input  logic [CSR_DATA_WIDTH-1:0]     avmm_writedata,
  input  logic [CSR_DATA_WIDTH/8-1:0]   avmm_byteenable,
  output logic [CSR_DATA_WIDTH-1:0]     avmm_readdata,
  output logic                          avmm_readdatavalid,
  output logic                          avmm_waitrequest,
  output logic                          irq_req,
  output logic [VEC_WIDTH-1:0]          irq_vec,
  input  logic                          irq_ack
);

  function automatic logic [NUM_IRQ_LINES-1:0] used_mask_f();
    logic [NUM_IRQ_LINES-1:0] m;
    for (int i = 0; i < NUM_IRQ_LINES; i++) m[i] = (i < NUM_IRQ_USED);
    return m;
  endfunction

  localparam logic [NUM_IRQ_LINES-1:0]  USED_MASK    = used_mask_f();
  localparam logic [63:0]               VERSION_VAL  = 64'h0000_0001_0000_0000;
  localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_STATUS  = CSR_ADDR_WIDTH'(0);
  localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_PENDING = CSR_ADDR_WIDTH'(1);
  localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MASK    = CSR_ADDR_WIDTH'(2);
  localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_COUNT   = CSR_ADDR_WIDTH'(3);
  localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_VERSION = CSR_ADDR_WIDTH'(4);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t                      state;
  logic [NUM_IRQ_LINES-1:0]    irq_q;
  logic [NUM_IRQ_LINES-1:0]    pending;
  logic [NUM_IRQ_LINES-1:0]    sent;
  logic [NUM_IRQ_LINES-1:0]    mask;
  logic [31:0]                 sent_count;
  logic [VEC_WIDTH-1:0]        rr_ptr;

  logic [NUM_IRQ_LINES-1:0]    rise;
  logic [NUM_IRQ_LINES-1:0]    w1c;
  logic [NUM_IRQ_LINES-1:0]    mask_rd;
  logic [NUM_IRQ_LINES-1:0]    eligible;
  logic [NUM_IRQ_LINES-1:0]    sent_next;
  logic                        wr_pending;
  logic                        wr_mask;
  logic                        wr_count;
  logic                        ack_take;
  logic                        grant_valid;
  logic [VEC_WIDTH-1:0]        grant_idx;
  logic [CSR_DATA_WIDTH-1:0]   rd_data;
  logic                        unused_bits;

  assign unused_bits = ^{avmm_writedata[CSR_DATA_WIDTH-1:NUM_IRQ_LINES],
                         avmm_byteenable[CSR_DATA_WIDTH/8-1:1]};

  assign avmm_waitrequest = 1'b0;

  assign rise       = irq_in & ~irq_q & USED_MASK;
  assign wr_pending = avmm_write && (avmm_address == ADDR_PENDING) && avmm_byteenable[0];
  assign wr_mask    = avmm_write && (avmm_address == ADDR_MASK) && avmm_byteenable[0];
  assign wr_count   = avmm_write && (avmm_address == ADDR_COUNT);
  assign w1c        = wr_pending ? (avmm_writedata[NUM_IRQ_LINES-1:0] & USED_MASK) : '0;
  assign mask_rd    = mask | ~USED_MASK;
  assign eligible   = pending & ~mask_rd & ~sent;
  assign ack_take   = (state == S_REQ) && irq_ack;

  // An ack only marks the line sent if its pending episode is still open; W1C wins over both.
  always_comb begin
    sent_next = sent;
    if (ack_take && pending[irq_vec]) sent_next[irq_vec] = 1'b1;
    sent_next = sent_next & ~w1c;
  end

  always_comb begin
    logic [VEC_WIDTH-1:0] idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int k = 0; k < NUM_IRQ_LINES; k++) begin
      idx = VEC_WIDTH'((int'(rr_ptr) + k) % NUM_IRQ_LINES);
      if (!grant_valid && eligible[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (avmm_address)
      ADDR_STATUS:  rd_data[NUM_IRQ_LINES-1:0] = irq_q;
      ADDR_PENDING: rd_data[NUM_IRQ_LINES-1:0] = pending;
      ADDR_MASK:    rd_data[NUM_IRQ_LINES-1:0] = mask_rd;
      ADDR_COUNT:   rd_data[31:0] = sent_count;
      ADDR_VERSION: rd_data = CSR_DATA_WIDTH'(VERSION_VAL);
      default:      rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= S_IDLE;
      irq_q              <= '0;
      pending            <= '0;
      sent               <= '0;
      mask               <= '0;
      sent_count         <= '0;
      rr_ptr             <= '0;
      irq_req            <= 1'b0;
      irq_vec            <= '0;
      avmm_readdata      <= '0;
      avmm_readdatavalid <= 1'b0;
    end else begin
      irq_q   <= irq_in;
      pending <= (pending & ~w1c) | rise;
      sent    <= sent_next;

      if (wr_mask) mask <= avmm_writedata[NUM_IRQ_LINES-1:0] & USED_MASK;

      // A clear landing together with an ack leaves the counter at zero.
      if (wr_count)
        sent_count <= '0;
      else if (ack_take && (sent_count != 32'hFFFF_FFFF))
        sent_count <= sent_count + 32'd1;

      avmm_readdatavalid <= avmm_read;
      avmm_readdata      <= avmm_read ? rd_data : '0;

      case (state)
        S_IDLE: begin
          if (grant_valid) begin
            irq_vec <= grant_idx;
            irq_req <= 1'b1;
            state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (irq_ack) begin
            irq_req <= 1'b0;
            rr_ptr  <= VEC_WIDTH'((int'(irq_vec) + 1) % NUM_IRQ_LINES);
            state   <= S_IDLE;
          end
        end
        default: begin
          irq_req <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_asp_irq_ctrl.sv
// tb/tb_asp_irq_ctrl.sv - scoreboard bench for asp_irq_ctrl
module tb_asp_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  irq_in;
  logic [2:0]  avmm_address;
  logic        avmm_read;
  logic        avmm_write;
  logic [63:0] avmm_writedata;
  logic [7:0]  avmm_byteenable;
  logic [63:0] avmm_readdata;
  logic        avmm_readdatavalid;
  logic        avmm_waitrequest;
  logic        irq_req;
  logic [1:0]  irq_vec;
  logic        irq_ack;

  asp_irq_ctrl dut (
    .clk                (clk),
    .reset              (reset),
    .irq_in             (irq_in),
    .avmm_address       (avmm_address),
    .avmm_read          (avmm_read),
    .avmm_write         (avmm_write),
    .avmm_writedata     (avmm_writedata),
    .avmm_byteenable    (avmm_byteenable),
    .avmm_readdata      (avmm_readdata),
    .avmm_readdatavalid (avmm_readdatavalid),
    .avmm_waitrequest   (avmm_waitrequest),
    .irq_req            (irq_req),
    .irq_vec            (irq_vec),
    .irq_ack            (irq_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  addr;
    logic [63:0] data;
  } rd_exp_t;

  rd_exp_t     exp_rd[$];
  logic [1:0]  exp_vec[$];
  int          checks = 0;
  int          errors = 0;
  logic        prev_req = 1'b0;
  rd_exp_t     mon_rd;
  logic [1:0]  mon_vec;

  localparam logic [63:0] VERSION = 64'h0000_0001_0000_0000;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: pops expected values whenever the DUT presents a read response or a new request.
  always @(negedge clk) begin
    if (avmm_readdatavalid === 1'b1) begin
      if (exp_rd.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read_response: got 0x%0h, required none", avmm_readdata);
      end else begin
        mon_rd = exp_rd.pop_front();
        chk($sformatf("read_addr%0d", mon_rd.addr), avmm_readdata, mon_rd.data);
      end
    end
    if (irq_req === 1'b1 && prev_req !== 1'b1) begin
      if (exp_vec.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_irq_req: got vec %0d, required no request", irq_vec);
      end else begin
        mon_vec = exp_vec.pop_front();
        chk("irq_vec", {62'd0, irq_vec}, {62'd0, mon_vec});
      end
    end
    prev_req = irq_req;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    irq_in         = '0;
    irq_ack        = 1'b0;
    avmm_read      = 1'b0;
    avmm_write     = 1'b0;
    avmm_address   = '0;
    avmm_writedata = '0;
    avmm_byteenable = 8'hFF;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic csr_write(input logic [2:0] a, input logic [63:0] d, input logic [7:0] be = 8'hFF);
    avmm_address    = a;
    avmm_writedata  = d;
    avmm_byteenable = be;
    avmm_write      = 1'b1;
    tick();
    avmm_write      = 1'b0;
    avmm_byteenable = 8'hFF;
  endtask

  task automatic csr_read(input logic [2:0] a, input logic [63:0] e);
    exp_rd.push_back('{a, e});
    avmm_address = a;
    avmm_read    = 1'b1;
    tick();
    avmm_read    = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (irq_req !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("irq_req_within_budget", {63'd0, irq_req}, 64'd1);
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    irq_in          = '0;
    irq_ack         = 1'b0;
    avmm_read       = 1'b0;
    avmm_write      = 1'b0;
    avmm_address    = '0;
    avmm_writedata  = '0;
    avmm_byteenable = 8'hFF;

    // Reset state and single-line timing
    do_reset();
    chk("rst_irq_req", {63'd0, irq_req}, 64'd0);
    chk("rst_irq_vec", {62'd0, irq_vec}, 64'd0);
    chk("rst_rdvalid", {63'd0, avmm_readdatavalid}, 64'd0);
    chk("rst_waitreq", {63'd0, avmm_waitrequest}, 64'd0);
    chk("rst_readdata", avmm_readdata, 64'd0);
    csr_read(0, 64'h0);
    csr_read(1, 64'h0);
    csr_read(2, 64'h8);
    csr_read(3, 64'h0);
    csr_read(4, VERSION);
    csr_read(6, 64'h0);
    ack();
    csr_read(3, 64'h0);
    exp_vec.push_back(2'd1);
    irq_in = 4'b0010;
    tick();
    chk("t1_req_cycle1", {63'd0, irq_req}, 64'd0);
    tick();
    chk("t1_req_cycle2", {63'd0, irq_req}, 64'd1);
    chk("t1_vec_cycle2", {62'd0, irq_vec}, 64'd1);
    tick();
    chk("t1_req_hold_cycle3", {63'd0, irq_req}, 64'd1);
    tick();
    ack();
    chk("t1_req_after_ack", {63'd0, irq_req}, 64'd0);
    csr_read(3, 64'h1);
    csr_read(1, 64'h2);

    // Round-robin with wrap of rr_ptr
    do_reset();
    exp_vec.push_back(2'd0);
    exp_vec.push_back(2'd2);
    irq_in = 4'b0101;
    wait_req(); ack();
    wait_req(); ack();
    irq_in = 4'b0000;
    tick();
    csr_write(1, 64'h5);
    exp_vec.push_back(2'd0);
    exp_vec.push_back(2'd2);
    irq_in = 4'b0101;
    wait_req(); ack();
    wait_req(); ack();
    csr_read(3, 64'h4);

    // Masking, unused mask bits, write/read ordering, byte enables
    do_reset();
    csr_write(2, 64'h1);
    irq_in = 4'b0001;
    repeat (5) tick();
    chk("t3_masked_no_req", {63'd0, irq_req}, 64'd0);
    exp_vec.push_back(2'd0);
    csr_write(2, 64'h0);
    chk("t3_unmask_cycle1", {63'd0, irq_req}, 64'd0);
    tick();
    chk("t3_unmask_cycle2", {63'd0, irq_req}, 64'd1);
    ack();
    csr_read(2, 64'h8);
    exp_rd.push_back('{3'd2, 64'h8});
    avmm_address   = 3'd2;
    avmm_writedata = 64'h3;
    avmm_write     = 1'b1;
    avmm_read      = 1'b1;
    tick();
    avmm_write = 1'b0;
    avmm_read  = 1'b0;
    csr_read(2, 64'hB);
    csr_write(2, 64'h0, 8'hFE);
    csr_read(2, 64'hB);
    csr_write(2, 64'h0);

    // No re-delivery until W1C plus new edge
    do_reset();
    exp_vec.push_back(2'd2);
    irq_in = 4'b0100;
    wait_req(); ack();
    irq_in = 4'b0000;
    tick();
    irq_in = 4'b0100;
    repeat (6) tick();
    chk("t4_no_redelivery", {63'd0, irq_req}, 64'd0);
    csr_read(1, 64'h4);
    csr_write(1, 64'h4);
    exp_vec.push_back(2'd2);
    irq_in = 4'b0000;
    tick();
    irq_in = 4'b0100;
    wait_req(); ack();
    csr_read(3, 64'h2);

    // Edge and W1C collide; unused line 3 never pends
    do_reset();
    exp_vec.push_back(2'd0);
    irq_in = 4'b0001;
    wait_req(); ack();
    irq_in = 4'b0000;
    tick();
    exp_vec.push_back(2'd0);
    irq_in = 4'b1001;
    csr_write(1, 64'h1);
    csr_read(1, 64'h1);
    csr_read(0, 64'h9);
    wait_req(); ack();
    irq_in = 4'b0001;
    tick();
    irq_in = 4'b1001;
    tick();
    csr_read(1, 64'h1);

    // W1C of in-flight line, then count clear colliding with ack
    do_reset();
    exp_vec.push_back(2'd2);
    irq_in = 4'b0100;
    wait_req();
    csr_write(1, 64'h4);
    chk("t6_req_not_withdrawn", {63'd0, irq_req}, 64'd1);
    chk("t6_vec_held", {62'd0, irq_vec}, 64'd2);
    ack();
    csr_read(1, 64'h0);
    csr_read(3, 64'h1);
    irq_in = 4'b0000;
    tick();
    exp_vec.push_back(2'd2);
    irq_in = 4'b0100;
    wait_req();
    irq_ack        = 1'b1;
    avmm_address   = 3'd3;
    avmm_writedata = 64'h0;
    avmm_write     = 1'b1;
    tick();
    irq_ack    = 1'b0;
    avmm_write = 1'b0;
    csr_read(3, 64'h0);

    // Reset while a request is in flight
    do_reset();
    exp_vec.push_back(2'd0);
    irq_in = 4'b0001;
    wait_req(); ack();
    exp_vec.push_back(2'd1);
    irq_in = 4'b0011;
    wait_req();
    reset        = 1'b1;
    irq_in       = 4'b0000;
    avmm_address = 3'd4;
    avmm_read    = 1'b1;
    tick();
    reset     = 1'b0;
    avmm_read = 1'b0;
    chk("t7_irq_req", {63'd0, irq_req}, 64'd0);
    chk("t7_irq_vec", {62'd0, irq_vec}, 64'd0);
    chk("t7_rdvalid", {63'd0, avmm_readdatavalid}, 64'd0);
    chk("t7_readdata", avmm_readdata, 64'd0);
    chk("t7_waitreq", {63'd0, avmm_waitrequest}, 64'd0);
    csr_read(1, 64'h0);
    csr_read(3, 64'h0);

    repeat (3) tick();
    chk("rd_queue_drained", 64'(exp_rd.size()), 64'd0);
    chk("vec_queue_drained", 64'(exp_vec.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
